// File: rtl/gcd_job_queue.sv
// gcd_job_queue: bus-mapped job/result FIFOs feeding an external GCD core
// Ports: clk, reset (async, active-high); bus saddress/srd/swr/sdata_in/sdata_out;
//        core_a/core_b/core_start to the core, core_busy/core_result from it; irq = results pending.
// Map: 0x108 OPA (W), 0x10C OPB push (W), 0x110 RES pop (R), 0x114 STAT (R) / sticky clear (W).
// Build option: define GCD_ZERO_CHECK_EN to reject jobs with a zero operand (STAT[11]).
module gcd_job_queue (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_start,
    input  logic        core_busy,
    input  logic [31:0] core_result,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, STORE} state_t;
    state_t state, state_nx;
    logic srd_q, swr_q, ovf, unf, zr, zero;
    logic [31:0] opa, stat;
    logic [31:0] job_a [4];
    logic [31:0] job_b [4];
    logic [31:0] res [4];
    logic [1:0] jwp, jrp, rwp, rrp;
    logic [2:0] jcnt, rcnt;
    logic rd, wr, j_req, j_push, j_pop, r_push, r_rd, r_pop, stat_wr;
`ifdef GCD_ZERO_CHECK_EN
    assign zero = opa == 32'd0 || sdata_in == 32'd0;
`else
    assign zero = 1'b0;
`endif
    assign rd = srd & ~srd_q;
    assign wr = swr & ~swr_q;
    assign j_req = wr && saddress == 16'h010C && !zero;
    assign j_push = j_req && jcnt != 3'd4;
    assign j_pop = state == ISSUE;
    assign r_push = state == STORE;
    assign r_rd = rd && saddress == 16'h0110;
    assign r_pop = r_rd && rcnt != 3'd0;
    assign stat_wr = wr && saddress == 16'h0114;
    assign irq = rcnt != 3'd0;
    assign stat = {20'd0, zr, unf, ovf, state != IDLE, rcnt == 3'd0, jcnt == 3'd4, rcnt, jcnt};
    always_comb begin
        state_nx = state;
        core_start = 1'b0;
        case (state)
            IDLE:      state_nx = (jcnt != 3'd0 && rcnt != 3'd4) ? ISSUE : IDLE;
            ISSUE: begin
                core_start = 1'b1;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: state_nx = core_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_nx = core_busy ? WAIT_DONE : STORE;
            STORE:     state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    // FIFO storage is left unreset; only pointers and counts define occupancy.
    always_ff @(posedge clk) begin
        if (j_push) begin
            job_a[jwp] <= opa;
            job_b[jwp] <= sdata_in;
        end
        if (r_push) res[rwp] <= core_result;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            srd_q <= 1'b0;
            swr_q <= 1'b0;
            opa <= '0;
            jwp <= '0;
            jrp <= '0;
            rwp <= '0;
            rrp <= '0;
            jcnt <= '0;
            rcnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            zr <= 1'b0;
            sdata_out <= '0;
            core_a <= '0;
            core_b <= '0;
        end else begin
            state <= state_nx;
            srd_q <= srd;
            swr_q <= swr;
            if (wr && saddress == 16'h0108) opa <= sdata_in;
            if (j_push) jwp <= jwp + 2'd1;
            if (j_pop) jrp <= jrp + 2'd1;
            if (r_push) rwp <= rwp + 2'd1;
            if (r_pop) rrp <= rrp + 2'd1;
            jcnt <= jcnt + {2'd0, j_push} - {2'd0, j_pop};
            rcnt <= rcnt + {2'd0, r_push} - {2'd0, r_pop};
            // Operands are latched on entry to ISSUE so they are valid during the start pulse.
            if (state == IDLE && state_nx == ISSUE) begin
                core_a <= job_a[jrp];
                core_b <= job_b[jrp];
            end
            // Setting a sticky bit wins over a simultaneous clear.
            ovf <= (ovf & ~(stat_wr & sdata_in[9])) | (j_req && jcnt == 3'd4);
            unf <= (unf & ~(stat_wr & sdata_in[10])) | (r_rd && rcnt == 3'd0);
            zr <= (zr & ~(stat_wr & sdata_in[11])) | (wr && saddress == 16'h010C && zero);
            if (r_rd) sdata_out <= rcnt != 3'd0 ? res[rrp] : 32'd0;
            else if (rd && saddress == 16'h0114) sdata_out <= stat;
        end
    end
endmodule
